// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream multiplexer with valid/ready
// handshakes on every input and on the output.
//   mode=0 : explicit channel select via sel (out-of-range sel never grants)
//   mode=1 : round-robin arbitration starting at rr_ptr, wrapping at NUM_CH
// The output is one register stage, so the latency is 1 cycle and a beat
// can be accepted every cycle.
// Optional build macro STREAM_MUX_PKT_LOCK_EN: when it is defined, the grant
// stays on one channel from its first non-last beat until its last beat is
// accepted. When it is undefined, arbitration is per beat and the last flag
// is only passed through.
module stream_mux_rr #(
   parameter  int NUM_CH = 4,
   parameter  int WIDTH  = 8,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_last,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_last,
   output logic [SEL_W-1:0]        out_chan,
   input  logic                    out_ready
);

   // Output register and arbitration state
   logic              r_out_valid;
   logic [WIDTH-1:0]  r_out_data;
   logic              r_out_last;
   logic [SEL_W-1:0]  r_out_chan;
   logic [SEL_W-1:0]  r_rr_ptr;

   // Combinational arbitration results
   logic              w_load;
   logic              w_sel_ok;
   logic              w_free_vld;
   logic [SEL_W-1:0]  w_free_ch;
   logic              w_gnt_vld;
   logic [SEL_W-1:0]  w_gnt_ch;
   logic [WIDTH-1:0]  w_gnt_data;
   logic              w_gnt_last;
   logic              w_accept;
   logic              w_ptr_adv;
   logic [SEL_W-1:0]  w_ptr_next;
   logic [NUM_CH-1:0] w_in_ready;

   // The output register can take a new beat when empty or being drained
   assign w_load   = !r_out_valid || out_ready;

   // An out-of-range select (possible when NUM_CH is not a power of two)
   // never grants
   assign w_sel_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_CH));

   // Per-beat grant: explicit select, or first requester from rr_ptr with wrap
   always_comb begin
      logic [SEL_W:0] v_idx;
      w_free_vld = 1'b0;
      w_free_ch  = '0;
      v_idx      = '0;
      if (!mode) begin
         if (w_sel_ok) begin
            if (in_valid[sel]) begin
               w_free_vld = 1'b1;
               w_free_ch  = sel;
            end
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            v_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
            if (v_idx >= (SEL_W+1)'(NUM_CH)) begin
               v_idx = v_idx - (SEL_W+1)'(NUM_CH);
            end
            if (!w_free_vld && in_valid[v_idx[SEL_W-1:0]]) begin
               w_free_vld = 1'b1;
               w_free_ch  = v_idx[SEL_W-1:0];
            end
         end
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   typedef enum logic {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   lock_state_t      r_lock_state;
   logic [SEL_W-1:0] r_lock_ch;
   logic             r_lock_rr;

   // While locked, only the locked channel can be granted; mode, sel and the
   // other valids are ignored and a dropped valid simply produces no grant
   always_comb begin
      if (r_lock_state == ST_LOCKED) begin
         w_gnt_vld = in_valid[r_lock_ch];
         w_gnt_ch  = r_lock_ch;
      end else begin
         w_gnt_vld = w_free_vld;
         w_gnt_ch  = w_free_ch;
      end
   end

   // The pointer moves only when a packet completes; a packet that started
   // under round-robin advances it even though mode is ignored mid-packet
   always_comb begin
      if (r_lock_state == ST_LOCKED) begin
         w_ptr_adv = w_accept && w_gnt_last && r_lock_rr;
      end else begin
         w_ptr_adv = w_accept && w_gnt_last && mode;
      end
   end

   // Packet lock tracking: enter on an accepted non-last beat, leave on last
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_state <= ST_FREE;
         r_lock_ch    <= '0;
         r_lock_rr    <= 1'b0;
      end else if (w_accept) begin
         case (r_lock_state)
            ST_FREE: begin
               if (!w_gnt_last) begin
                  r_lock_state <= ST_LOCKED;
                  r_lock_ch    <= w_gnt_ch;
                  r_lock_rr    <= mode;
               end
            end
            ST_LOCKED: begin
               if (w_gnt_last) begin
                  r_lock_state <= ST_FREE;
               end
            end
            default: r_lock_state <= ST_FREE;
         endcase
      end
   end
`else
   // Per-beat arbitration: the grant is the free grant
   always_comb begin
      w_gnt_vld = w_free_vld;
      w_gnt_ch  = w_free_ch;
      w_ptr_adv = w_accept && mode;
   end
`endif

   assign w_gnt_data = in_data[w_gnt_ch*WIDTH +: WIDTH];
   assign w_gnt_last = in_last[w_gnt_ch];
   assign w_accept   = w_load && w_gnt_vld;

   // Next pointer wraps explicitly so non-power-of-two NUM_CH returns to 0
   assign w_ptr_next = ({1'b0, w_gnt_ch} == (SEL_W+1)'(NUM_CH - 1)) ?
                       '0 : (w_gnt_ch + SEL_W'(1));

   // Ready goes only to the granted channel and is held low during reset
   always_comb begin
      w_in_ready = '0;
      if (rst_n && w_accept) begin
         w_in_ready[w_gnt_ch] = 1'b1;
      end
   end

   // Output register: load the granted beat, or empty when nothing is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_chan  <= '0;
      end else if (w_load) begin
         r_out_valid <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_out_data <= w_gnt_data;
            r_out_last <= w_gnt_last;
            r_out_chan <= w_gnt_ch;
         end
      end
   end

   // Round-robin pointer: one past the last accepted round-robin grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_ptr_adv) begin
         r_rr_ptr <= w_ptr_next;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for the main
// behaviour and a 3-channel instance for non-power-of-two wrap and
// out-of-range select. Packet-lock steps follow STREAM_MUX_PKT_LOCK_EN.
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst_n;

   // 4-channel instance
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_chan;
   logic        out_ready;

   // 3-channel instance
   logic        mode3;
   logic [1:0]  sel3;
   logic [2:0]  in_valid3;
   logic [23:0] in_data3;
   logic [2:0]  in_last3;
   logic [2:0]  in_ready3;
   logic        out_valid3;
   logic [7:0]  out_data3;
   logic        out_last3;
   logic [1:0]  out_chan3;
   logic        out_ready3;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] ch_dat [4] = '{8'hA5, 8'h3C, 8'h33, 8'h44};

   stream_mux_rr #(.NUM_CH(4), .WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready)
   );

   stream_mux_rr #(.NUM_CH(3), .WIDTH(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
      .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3),
      .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
      .out_last(out_last3), .out_chan(out_chan3), .out_ready(out_ready3)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      mode       = 1'b1;
      sel        = 2'd0;
      in_valid   = 4'b1111;
      in_data    = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};
      in_last    = 4'b1111;
      out_ready  = 1'b1;
      mode3      = 1'b1;
      sel3       = 2'd0;
      in_valid3  = 3'b000;
      in_data3   = {8'hC2, 8'hB1, 8'hA0};
      in_last3   = 3'b111;
      out_ready3 = 1'b1;

      // Reset state, with requests present
      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data",  32'(out_data),  32'h0);
      check("rst_out_last",  32'(out_last),  32'h0);
      check("rst_out_chan",  32'(out_chan),  32'h0);
      check("rst_in_ready",  32'(in_ready),  32'h0);
      check("rst_in_ready3", 32'(in_ready3), 32'h0);

      // First beat after release
      rst_n    = 1'b1;
      in_valid = 4'b0001;
      #1;
      check("first_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("first_out_valid", 32'(out_valid), 32'h1);
      check("first_out_data",  32'(out_data),  32'hA5);
      check("first_out_chan",  32'(out_chan),  32'h0);

      // Asynchronous reset while a beat is held
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'h0);
      check("midrst_in_ready",  32'(in_ready),  32'h0);
      check("midrst_out_data",  32'(out_data),  32'h0);
      #1;
      rst_n = 1'b1;

      // Round-robin fairness, one beat per cycle
      in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("rr_in_ready_%0d", i), 32'(in_ready), 32'(4'b0001 << (i % 4)));
         tick();
         check($sformatf("rr_out_valid_%0d", i), 32'(out_valid), 32'h1);
         check($sformatf("rr_out_chan_%0d", i),  32'(out_chan),  32'(i % 4));
         check($sformatf("rr_out_data_%0d", i),  32'(out_data),  32'(ch_dat[i % 4]));
      end

      // Explicit select of channel 2
      mode = 1'b0;
      sel  = 2'd2;
      #1;
      check("sel2_in_ready", 32'(in_ready), 32'h4);
      tick();
      check("sel2_out_valid", 32'(out_valid), 32'h1);
      check("sel2_out_chan",  32'(out_chan),  32'h2);
      check("sel2_out_data",  32'(out_data),  32'h33);
      check("sel2_out_last",  32'(out_last),  32'h1);

      // Selected channel idle: no grant, output empties, fields hold
      in_valid = 4'b1011;
      #1;
      check("sel2_idle_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("sel2_idle_out_valid", 32'(out_valid), 32'h0);
      check("sel2_idle_out_data",  32'(out_data),  32'h33);
      check("sel2_idle_out_chan",  32'(out_chan),  32'h2);

      // Explicit mode left the pointer at 0
      mode     = 1'b1;
      in_valid = 4'b1111;
      #1;
      check("ptr_kept_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("ptr_kept_out_chan", 32'(out_chan), 32'h0);

      // Backpressure: load 0x3C from channel 1, then stall 5 cycles
      mode = 1'b0;
      sel  = 2'd1;
      #1;
      check("bp_load_in_ready", 32'(in_ready), 32'h2);
      tick();
      check("bp_load_out_data", 32'(out_data), 32'h3C);
      out_ready = 1'b0;
      sel       = 2'd3;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("bp_stall_in_ready_%0d", i), 32'(in_ready), 32'h0);
         tick();
         check($sformatf("bp_stall_valid_%0d", i), 32'(out_valid), 32'h1);
         check($sformatf("bp_stall_data_%0d", i),  32'(out_data),  32'h3C);
         check($sformatf("bp_stall_chan_%0d", i),  32'(out_chan),  32'h1);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'h8);
      tick();
      check("bp_release_valid", 32'(out_valid), 32'h1);
      check("bp_release_chan",  32'(out_chan),  32'h3);
      check("bp_release_data",  32'(out_data),  32'h44);
      in_valid = 4'b0000;
      tick();
      check("bp_drain_valid", 32'(out_valid), 32'h0);

      // Pointer is now 1; channel 1 sends a non-last beat while channel 0 waits
      mode     = 1'b1;
      in_valid = 4'b0011;
      in_last  = 4'b1101;
`ifdef STREAM_MUX_PKT_LOCK_EN
      #1;
      check("lock_b1_in_ready", 32'(in_ready), 32'h2);
      tick();
      check("lock_b1_chan", 32'(out_chan), 32'h1);
      check("lock_b1_last", 32'(out_last), 32'h0);
      mode = 1'b0;
      sel  = 2'd0;
      #1;
      check("lock_b2_in_ready", 32'(in_ready), 32'h2);
      tick();
      check("lock_b2_chan", 32'(out_chan), 32'h1);
      check("lock_b2_last", 32'(out_last), 32'h0);
      mode    = 1'b1;
      in_last = 4'b1111;
      #1;
      check("lock_b3_in_ready", 32'(in_ready), 32'h2);
      tick();
      check("lock_b3_chan", 32'(out_chan), 32'h1);
      check("lock_b3_last", 32'(out_last), 32'h1);
      #1;
      check("lock_after_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("lock_after_chan", 32'(out_chan), 32'h0);
`else
      #1;
      check("nolock_b1_in_ready", 32'(in_ready), 32'h2);
      tick();
      check("nolock_b1_chan", 32'(out_chan), 32'h1);
      check("nolock_b1_last", 32'(out_last), 32'h0);
      #1;
      check("nolock_b2_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("nolock_b2_chan", 32'(out_chan), 32'h0);
      check("nolock_b2_last", 32'(out_last), 32'h1);
`endif
      in_valid = 4'b0000;
      in_last  = 4'b1111;

      // 3-channel wrap: channel 2, then wrap to 0
      in_valid3 = 3'b100;
      #1;
      check("w3_b1_in_ready", 32'(in_ready3), 32'h4);
      tick();
      check("w3_b1_chan", 32'(out_chan3), 32'h2);
      check("w3_b1_data", 32'(out_data3), 32'hC2);
      in_valid3 = 3'b101;
      #1;
      check("w3_b2_in_ready", 32'(in_ready3), 32'h1);
      tick();
      check("w3_b2_chan", 32'(out_chan3), 32'h0);
      check("w3_b2_data", 32'(out_data3), 32'hA0);
      #1;
      check("w3_b3_in_ready", 32'(in_ready3), 32'h4);
      tick();
      check("w3_b3_chan", 32'(out_chan3), 32'h2);
      #1;
      check("w3_b4_in_ready", 32'(in_ready3), 32'h1);
      tick();
      check("w3_b4_chan", 32'(out_chan3), 32'h0);

      // 3-channel out-of-range select never grants
      mode3     = 1'b0;
      sel3      = 2'd3;
      in_valid3 = 3'b111;
      #1;
      check("w3_oor_in_ready", 32'(in_ready3), 32'h0);
      tick();
      check("w3_oor_valid", 32'(out_valid3), 32'h0);
      sel3 = 2'd1;
      #1;
      check("w3_sel1_in_ready", 32'(in_ready3), 32'h2);
      tick();
      check("w3_sel1_chan", 32'(out_chan3), 32'h1);
      check("w3_sel1_data", 32'(out_data3), 32'hB1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
